// File: rtl/floor_display_scan.sv
// floor_display_scan
// Time-multiplexed seven-segment driver for the elevator floor/status panel.
// NUM_DIGITS hex digits share one a..g bus; one digit is lit per scan slot.
// The first BLANK_CYCLES of every slot keep all anodes off so the previous
// digit's pattern never ghosts onto the next anode. Digits with blink enabled
// go dark during the OFF half of the blink period. Every output is registered,
// one cycle behind the scan state it is derived from.
module floor_display_scan #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 8,
   parameter int BLINK_FRAMES = 64,
   parameter bit SEG_ACT_LOW  = 1'b0
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digit_data,
   input  logic [NUM_DIGITS-1:0]   blink_en,
   input  logic [NUM_DIGITS-1:0]   dp_en,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int PC_W  = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PC_W-1:0]  PC_LAST   = PC_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(BLINK_FRAMES - 1);
   localparam logic [PC_W:0]    BLANK_LIM = (PC_W + 1)'(BLANK_CYCLES);

   // Inactive drive level of the segment and decimal-point pins.
   localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
   localparam logic       DP_OFF  = SEG_ACT_LOW;

   // Shadow copy of the display contents, updated only on load.
   logic [4*NUM_DIGITS-1:0] r_data;
   logic [NUM_DIGITS-1:0]   r_blink;
   logic [NUM_DIGITS-1:0]   r_dp;

   // Scan state.
   logic [PC_W-1:0]  r_pc;
   logic [IDX_W-1:0] r_idx;
   logic [FC_W-1:0]  r_frame_cnt;
   logic             r_phase_on;

   logic w_pc_wrap;
   logic w_frame_wrap;
   logic w_blank;
   logic w_dark;
   logic [3:0]            w_digit;
   logic [NUM_DIGITS-1:0] w_an_nxt;
   logic [6:0]            w_seg_nxt;
   logic                  w_dp_nxt;

   // Active-high hex to a..g pattern, seg[6]=a .. seg[0]=g.
   function automatic logic [6:0] f_hex_to_seg(input logic [3:0] hex);
      logic [6:0] pat;
      case (hex)
         4'h0: pat = 7'h7E;
         4'h1: pat = 7'h30;
         4'h2: pat = 7'h6D;
         4'h3: pat = 7'h79;
         4'h4: pat = 7'h33;
         4'h5: pat = 7'h5B;
         4'h6: pat = 7'h5F;
         4'h7: pat = 7'h70;
         4'h8: pat = 7'h7F;
         4'h9: pat = 7'h7B;
         4'hA: pat = 7'h77;
         4'hB: pat = 7'h1F;
         4'hC: pat = 7'h4E;
         4'hD: pat = 7'h3D;
         4'hE: pat = 7'h4F;
         default: pat = 7'h47;
      endcase
      return pat;
   endfunction

   assign w_pc_wrap    = (r_pc == PC_LAST);
   assign w_frame_wrap = w_pc_wrap && (r_idx == IDX_LAST);
   assign w_blank      = ({1'b0, r_pc} < BLANK_LIM);
   assign w_dark       = w_blank || (r_blink[r_idx] && !r_phase_on);
   assign w_digit      = r_data[{r_idx, 2'b00} +: 4];

   // Capture all three display vectors together so a digit set is never torn.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_data  <= '0;
         r_blink <= '0;
         r_dp    <= '0;
      end else if (load) begin
         r_data  <= digit_data;
         r_blink <= blink_en;
         r_dp    <= dp_en;
      end
   end

   // Slot prescaler and digit index; the index advances on the last slot cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pc  <= '0;
         r_idx <= '0;
      end else if (w_pc_wrap) begin
         r_pc  <= '0;
         r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
         r_pc  <= r_pc + PC_W'(1);
      end
   end

   // Count whole frames and flip the blink phase every BLINK_FRAMES frames.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_cnt <= '0;
         r_phase_on  <= 1'b1;
      end else if (w_frame_wrap) begin
         if (r_frame_cnt == FC_LAST) begin
            r_frame_cnt <= '0;
            r_phase_on  <= !r_phase_on;
         end else begin
            r_frame_cnt <= r_frame_cnt + FC_W'(1);
         end
      end
   end

   // Next pin values: dark during blank window or blink-off, else the lit digit.
   always_comb begin
      w_an_nxt  = '1;
      w_seg_nxt = SEG_OFF;
      w_dp_nxt  = DP_OFF;
      if (!w_dark) begin
         w_an_nxt[r_idx] = 1'b0;
         w_seg_nxt       = SEG_ACT_LOW ? ~f_hex_to_seg(w_digit) : f_hex_to_seg(w_digit);
         w_dp_nxt        = SEG_ACT_LOW ? ~r_dp[r_idx] : r_dp[r_idx];
      end
   end

   // Register the pins; frame_tick lands on the first cycle of slot 0.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         an         <= '1;
         seg        <= SEG_OFF;
         dp         <= DP_OFF;
         frame_tick <= 1'b0;
      end else begin
         an         <= w_an_nxt;
         seg        <= w_seg_nxt;
         dp         <= w_dp_nxt;
         frame_tick <= w_frame_wrap;
      end
   end

endmodule

// File: tb/tb_floor_display_scan.sv
// Directed bench for floor_display_scan with a fast scan (4 cycles per slot,
// 1 blank cycle, blink every 2 frames). A second instance built for a
// common-anode board shares all inputs and must show inverted seg/dp.
module tb_floor_display_scan;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        load;
   logic [15:0] digit_data;
   logic [3:0]  blink_en;
   logic [3:0]  dp_en;
   logic [6:0]  seg, seg_i;
   logic        dp, dp_i;
   logic [3:0]  an, an_i;
   logic        ft, ft_i;

   int n_checks = 0;
   int n_errors = 0;

   // Posedges since the last reset release, and the bench's copy of the shadow.
   int          n;
   logic [15:0] sh_data;
   logic [3:0]  sh_blink;
   logic [3:0]  sh_dp;

   logic [6:0]  dec_tab [16];
   logic [3:0]  t2_an  [16];
   logic [6:0]  t2_seg [16];

   always #5 clock = ~clock;

   floor_display_scan #(
      .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2), .SEG_ACT_LOW(1'b0)
   ) u_dut (
      .clock(clock), .reset_n(reset_n), .load(load), .digit_data(digit_data),
      .blink_en(blink_en), .dp_en(dp_en), .seg(seg), .dp(dp), .an(an), .frame_tick(ft)
   );

   floor_display_scan #(
      .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2), .SEG_ACT_LOW(1'b1)
   ) u_inv (
      .clock(clock), .reset_n(reset_n), .load(load), .digit_data(digit_data),
      .blink_en(blink_en), .dp_en(dp_en), .seg(seg_i), .dp(dp_i), .an(an_i), .frame_tick(ft_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (n=%0d, t=%0t)", tag, got, exp, n, $time);
      end
   endtask

   // One clock with the full expected-output model checked at the next negedge.
   task automatic tick();
      logic [15:0] pd;
      logic [3:0]  pb, pdp, ea;
      logic [6:0]  es, es_inv;
      logic        ed, ed_inv, off, lit;
      int          p, s;
      pd  = sh_data;
      pb  = sh_blink;
      pdp = sh_dp;
      if (load) begin
         sh_data  = digit_data;
         sh_blink = blink_en;
         sh_dp    = dp_en;
      end
      @(posedge clock);
      n++;
      @(negedge clock);
      p   = (n - 1) % 4;
      s   = ((n - 1) / 4) % 4;
      off = (((n - 1) / 32) % 2) == 1;
      lit = (p != 0) && !(pb[s] && off);
      ea  = lit ? ~(4'b0001 << s) : 4'hF;
      es  = lit ? dec_tab[pd[4*s +: 4]] : 7'h00;
      ed  = lit && pdp[s];
      es_inv = ~es;
      ed_inv = ~ed;
      check("an", an, ea);
      check("seg", seg, es);
      check("dp", dp, ed);
      check("frame_tick", ft, (n % 16) == 0);
      check("inv_an", an_i, ea);
      check("inv_seg", seg_i, es_inv);
      check("inv_dp", dp_i, ed_inv);
      check("inv_frame_tick", ft_i, (n % 16) == 0);
      check("onecold", ($countones(~an) <= 1), 1'b1);
   endtask

   task automatic check_reset_levels(input string tag);
      check({tag, "_an"}, an, 4'hF);
      check({tag, "_seg"}, seg, 7'h00);
      check({tag, "_dp"}, dp, 1'b0);
      check({tag, "_ft"}, ft, 1'b0);
      check({tag, "_inv_seg"}, seg_i, 7'h7F);
      check({tag, "_inv_dp"}, dp_i, 1'b1);
   endtask

   // Reset, then release with load held so the first edge captures the contents.
   task automatic do_reset(input logic [15:0] d, input logic [3:0] b, input logic [3:0] dpv);
      load    = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check_reset_levels("rst");
      sh_data    = '0;
      sh_blink   = '0;
      sh_dp      = '0;
      n          = 0;
      digit_data = d;
      blink_en   = b;
      dp_en      = dpv;
      load       = 1'b1;
      reset_n    = 1'b1;
      tick();
      load = 1'b0;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int ft_cnt;
      logic [3:0]  v;
      logic [6:0]  inv;

      dec_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
      t2_an   = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                  4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
      t2_seg  = '{7'h00, 7'h30, 7'h30, 7'h30, 7'h00, 7'h6D, 7'h6D, 7'h6D,
                  7'h00, 7'h79, 7'h79, 7'h79, 7'h00, 7'h33, 7'h33, 7'h33};
      n = 0;
      sh_data = '0; sh_blink = '0; sh_dp = '0;
      reset_n = 1'b0;
      load = 1'b0;
      digit_data = 16'hFFFF;
      blink_en = 4'hF;
      dp_en = 4'hF;

      // T1: reset held for 10 cycles
      repeat (10) @(negedge clock);
      check_reset_levels("t1_hold");

      // T2: scan order, blank cycle, decimal points, frame_tick rate
      do_reset(16'h4321, 4'b0000, 4'b0101);
      ft_cnt = 0;
      repeat (32) begin
         tick();
         check("t2_an_tab", an, t2_an[(n - 1) % 16]);
         check("t2_seg_tab", seg, t2_seg[(n - 1) % 16]);
         if (ft) ft_cnt++;
      end
      check("t2_ft_count", ft_cnt, 2);

      // T3: every hex code in digit 0, both polarities
      for (int k = 0; k < 16; k++) begin
         v = 4'(k);
         do_reset({12'h000, v}, 4'b0000, 4'b0000);
         tick();
         inv = ~dec_tab[v];
         check("t3_seg", seg, dec_tab[v]);
         check("t3_inv_seg", seg_i, inv);
         check("t3_an", an, 4'hE);
         check("t3_inv_an", an_i, 4'hE);
      end

      // T4: digit 1 blinks, others stay lit
      do_reset(16'h4321, 4'b0010, 4'b0000);
      repeat (127) begin
         tick();
         if ((n - 1) % 16 == 6)
            check("t4_digit1", an, ((((n - 1) / 16) % 4) >= 2) ? 4'hF : 4'hD);
         if ((n - 1) % 16 == 10)
            check("t4_digit2", an, 4'hB);
      end

      // T5: load while digit 2 is lit, then load on the last cycle of a slot
      do_reset(16'h4321, 4'b0000, 4'b0000);
      repeat (8) tick();
      digit_data = 16'h9876;
      load = 1'b1;
      tick();
      load = 1'b0;
      digit_data = 16'h0000;
      tick();
      check("t5_new_digit2", seg, 7'h7F);
      tick();
      check("t5_new_digit2_hold", seg, 7'h7F);
      repeat (32) tick();
      while ((n % 4) != 3) tick();
      digit_data = 16'h1111;
      load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      check("t5_slot_blank", an == 4'hF, 1'b1);
      tick();
      check("t5_slot_new", seg, 7'h30);

      // T1: asynchronous reset in the middle of a lit cycle
      while ((n % 4) == 0) tick();
      @(posedge clock);
      #2;
      check("t1_prelit", an == 4'hF, 1'b0);
      #1 reset_n = 1'b0;
      #1;
      check_reset_levels("t1_async");

      // T6: random loads with ignored input churn in between
      do_reset(16'hA5C3, 4'b1001, 4'b0110);
      repeat (10000) begin
         digit_data = 16'($urandom);
         blink_en   = 4'($urandom);
         dp_en      = 4'($urandom);
         load       = ($urandom_range(0, 15) == 0);
         tick();
      end
      load = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
